// File: rtl/aes_key_expand_seq.sv
// ---------------------------------------------------------------------------
// aes_key_expand_seq
//   Sequential AES-128 key-schedule engine. Holds the current round key in a
//   register, rotates its last word, substitutes it through a single SubWord
//   instance, XORs in Rcon and derives the next round key. Round keys 0..10
//   are presented one per accepted valid/ready handshake.
//
// Optional feature (macro AES_KEY_STORE_EN):
//   Adds an 11-entry round-key store written on each accepted handshake, with
//   a combinational read port (i_rd_idx / o_rd_key) so the decrypt path can
//   fetch round keys in reverse order. Indices above 10 read as zero. The
//   store is cleared by reset only.
//
// Ports:
//   i_clk        rising-edge clock
//   i_rst        asynchronous active-high reset
//   i_start      one-cycle request to expand i_key_in (sampled in IDLE only)
//   i_key_in     cipher key, [127:96] = w0 ... [31:0] = w3
//   i_rk_ready   consumer accepts o_round_key this cycle
//   o_rk_valid   o_round_key / o_round_idx are valid
//   o_round_key  current round key (same word order as i_key_in)
//   o_round_idx  index of o_round_key, 0..10
//   o_busy       high in every state other than IDLE
//   o_done       one-cycle pulse after round 10 is accepted
//   i_rd_idx     (AES_KEY_STORE_EN) key-store read index
//   o_rd_key     (AES_KEY_STORE_EN) key-store read data
// ---------------------------------------------------------------------------

// SubWord: byte-wise AES S-box substitution of one word.
module aes_subword #(
    parameter int BYTE  = 8,
    parameter int DWORD = 32
) (
    input  logic [DWORD-1:0] i_word,
    output logic [DWORD-1:0] o_word
);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    for (genvar g = 0; g < DWORD / BYTE; g++) begin : g_byte
        assign o_word[g*BYTE +: BYTE] = SBOX[i_word[g*BYTE +: BYTE]];
    end

endmodule

module aes_key_expand_seq #(
    parameter int BYTE       = 8,
    parameter int DWORD      = 32,
    parameter int LENGTH     = 128,
    parameter int NUM_ROUNDS = 10
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [LENGTH-1:0] i_key_in,
    input  logic              i_rk_ready,
`ifdef AES_KEY_STORE_EN
    input  logic [3:0]        i_rd_idx,
    output logic [LENGTH-1:0] o_rd_key,
`endif
    output logic              o_rk_valid,
    output logic [LENGTH-1:0] o_round_key,
    output logic [3:0]        o_round_idx,
    output logic              o_busy,
    output logic              o_done
);

    localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t            r_state;
    logic [LENGTH-1:0] r_round_key;
    logic [3:0]        r_round_idx;
    logic [7:0]        r_rcon;
    logic              r_rk_valid;
    logic              r_busy;
    logic              r_done;

    logic [DWORD-1:0]  w_w0, w_w1, w_w2, w_w3;
    logic [DWORD-1:0]  w_rot;
    logic [DWORD-1:0]  w_sub;
    logic [DWORD-1:0]  w_t;
    logic [DWORD-1:0]  w_n0, w_n1, w_n2, w_n3;
    logic [LENGTH-1:0] w_next_key;
    logic [7:0]        w_rcon_next;
    logic              w_accept;

    assign w_w0 = r_round_key[127:96];
    assign w_w1 = r_round_key[95:64];
    assign w_w2 = r_round_key[63:32];
    assign w_w3 = r_round_key[31:0];

    // RotWord: left-rotate by one byte.
    assign w_rot = {w_w3[23:0], w_w3[31:24]};

    aes_subword #(
        .BYTE  (BYTE),
        .DWORD (DWORD)
    ) u_subword (
        .i_word (w_rot),
        .o_word (w_sub)
    );

    assign w_t  = w_sub ^ {r_rcon, 24'h0};
    assign w_n0 = w_w0 ^ w_t;
    assign w_n1 = w_w1 ^ w_n0;
    assign w_n2 = w_w2 ^ w_n1;
    assign w_n3 = w_w3 ^ w_n2;
    assign w_next_key = {w_n0, w_n1, w_n2, w_n3};

    // xtime in GF(2^8): 0x80 wraps to 0x1B.
    assign w_rcon_next = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1B : 8'h00);

    assign w_accept = r_rk_valid && i_rk_ready;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_round_key <= '0;
            r_round_idx <= '0;
            r_rcon      <= 8'h01;
            r_rk_valid  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (i_start) begin
                        r_round_key <= i_key_in;
                        r_round_idx <= '0;
                        r_rcon      <= 8'h01;
                        r_rk_valid  <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= EMIT;
                    end
                end
                EMIT: begin
                    if (w_accept) begin
                        if (r_round_idx < LAST_IDX) begin
                            r_round_key <= w_next_key;
                            r_round_idx <= r_round_idx + 4'd1;
                            r_rcon      <= w_rcon_next;
                        end else begin
                            r_rk_valid <= 1'b0;
                            r_done     <= 1'b1;
                            r_state    <= FIN;
                        end
                    end
                end
                FIN: begin
                    // start is deliberately not looked at here.
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state    <= IDLE;
                    r_rk_valid <= 1'b0;
                    r_busy     <= 1'b0;
                    r_done     <= 1'b0;
                end
            endcase
        end
    end

    assign o_rk_valid  = r_rk_valid;
    assign o_round_key = r_round_key;
    assign o_round_idx = r_round_idx;
    assign o_busy      = r_busy;
    assign o_done      = r_done;

`ifdef AES_KEY_STORE_EN
    logic [LENGTH-1:0] r_store [0:10];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < 11; i++) begin
                r_store[i] <= '0;
            end
        end else if (r_state == EMIT && w_accept) begin
            r_store[r_round_idx] <= r_round_key;
        end
    end

    always_comb begin
        o_rd_key = '0;
        if (i_rd_idx <= LAST_IDX) begin
            o_rd_key = r_store[i_rd_idx];
        end
    end
`endif

endmodule

// File: tb/tb_aes_key_expand_seq.sv
module tb_aes_key_expand_seq;

    logic         clk;
    logic         rst;
    logic         start;
    logic [127:0] key_in;
    logic         rk_ready;
    logic         rk_valid;
    logic [127:0] round_key;
    logic [3:0]   round_idx;
    logic         busy;
    logic         done;
`ifdef AES_KEY_STORE_EN
    logic [3:0]   rd_idx;
    logic [127:0] rd_key;
`endif

    aes_key_expand_seq dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .i_key_in    (key_in),
        .i_rk_ready  (rk_ready),
`ifdef AES_KEY_STORE_EN
        .i_rd_idx    (rd_idx),
        .o_rd_key    (rd_key),
`endif
        .o_rk_valid  (rk_valid),
        .o_round_key (round_key),
        .o_round_idx (round_idx),
        .o_busy      (busy),
        .o_done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIPS-197 Appendix A.1 schedule and the all-zero-key schedule.
    logic [127:0] fips_rk [0:10];
    logic [127:0] zero_rk [0:10];
    initial begin
        fips_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
        fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        zero_rk[0]  = 128'h00000000000000000000000000000000;
        zero_rk[1]  = 128'h62636363626363636263636362636363;
        zero_rk[2]  = 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa;
        zero_rk[3]  = 128'h90973450696ccffaf2f457330b0fac99;
        zero_rk[4]  = 128'hee06da7b876a1581759e42b27e91ee2b;
        zero_rk[5]  = 128'h7f2e2b88f8443e098dda7cbbf34b9290;
        zero_rk[6]  = 128'hec614b851425758c99ff09376ab49ba7;
        zero_rk[7]  = 128'h217517873550620bacaf6b3cc61bf09b;
        zero_rk[8]  = 128'h0ef903333ba9613897060a04511dfa9f;
        zero_rk[9]  = 128'hb1d4d8e28a7db9da1d7bb3de4c664941;
        zero_rk[10] = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
    end

    typedef struct {
        logic [127:0] key;
        logic [3:0]   idx;
    } exp_t;

    exp_t exp_q [$];

    int n_cmp = 0;
    int n_err = 0;
    int hs_cnt = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic push_keys(input bit use_zero, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.key = use_zero ? zero_rk[i] : fips_rk[i];
            e.idx = 4'(i);
            exp_q.push_back(e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every handshake visible mid-cycle pops one expected entry;
    // a stalled output must be unchanged on the following cycle.
    logic         prev_stall = 1'b0;
    logic [127:0] prev_key;
    logic [3:0]   prev_idx;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall && rk_valid) begin
                chk("stall_key_stable", round_key, prev_key);
                chk("stall_idx_stable", {124'b0, round_idx}, {124'b0, prev_idx});
            end
            if (rk_valid && rk_ready) begin
                hs_cnt++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_handshake: got idx %0d key %h, expected none", round_idx, round_key);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("round_key", round_key, e.key);
                    chk("round_idx", {124'b0, round_idx}, {124'b0, e.idx});
                end
            end
            prev_stall <= rk_valid && !rk_ready;
            prev_key   <= round_key;
            prev_idx   <= round_idx;
        end
    end

    task automatic wait_idx(input logic [3:0] target);
        int n;
        n = 0;
        while (!(rk_valid && round_idx == target) && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_idx_timeout: got idx %0d expected %0d", round_idx, target);
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_done_timeout: got done 0 expected 1");
        end
    endtask

    task automatic pulse_start(input logic [127:0] k);
        key_in = k;
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    int hs_before;
    int pat;

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        key_in   = '0;
        rk_ready = 1'b0;
`ifdef AES_KEY_STORE_EN
        rd_idx   = '0;
`endif
        #12;
        chk("reset_valid", {127'b0, rk_valid}, 128'd0);
        chk("reset_key", round_key, 128'd0);
        chk("reset_idx", {124'b0, round_idx}, 128'd0);
        chk("reset_busy", {127'b0, busy}, 128'd0);
        chk("reset_done", {127'b0, done}, 128'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        tick();

        // Run 1: FIPS key, ready held high, exact cycle timing.
        rk_ready = 1'b1;
        push_keys(1'b0, 11);
        key_in = fips_rk[0];
        start  = 1'b1;
        chk("valid_before_start", {127'b0, rk_valid}, 128'd0);
        tick();
        start  = 1'b0;
        key_in = 128'hdeadbeef_deadbeef_deadbeef_deadbeef;
        chk("valid_after_start", {127'b0, rk_valid}, 128'd1);
        for (int i = 0; i < 11; i++) begin
            chk("valid_streak", {127'b0, rk_valid}, 128'd1);
            chk("busy_streak", {127'b0, busy}, 128'd1);
            tick();
        end
        chk("done_pulse", {127'b0, done}, 128'd1);
        chk("valid_in_fin", {127'b0, rk_valid}, 128'd0);
        chk("busy_in_fin", {127'b0, busy}, 128'd1);
        tick();
        chk("done_low", {127'b0, done}, 128'd0);
        chk("busy_low", {127'b0, busy}, 128'd0);
        tick();

        // Run 2: backpressure pattern 1,0,0,1,... ; 11 handshakes total.
        push_keys(1'b0, 11);
        hs_before = hs_cnt;
        pat = 0;
        rk_ready = 1'b1;
        pulse_start(fips_rk[0]);
        for (int n = 0; n < 200 && !done; n++) begin
            rk_ready = (pat % 4 == 0) || (pat % 4 == 3);
            pat++;
            tick();
        end
        chk("bp_done_seen", {127'b0, done}, 128'd1);
        chk("bp_handshakes", 128'(hs_cnt - hs_before), 128'd11);
        rk_ready = 1'b1;
        tick();
        tick();

        // Run 3: start re-asserted mid-run with another key, and again with done.
        push_keys(1'b0, 11);
        pulse_start(fips_rk[0]);
        wait_idx(4'd4);
        pulse_start(128'h0);
        wait_done();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_at_done_valid", {127'b0, rk_valid}, 128'd0);
        chk("start_at_done_busy", {127'b0, busy}, 128'd0);
        tick();
        chk("start_at_done_idle", {127'b0, busy}, 128'd0);

`ifdef AES_KEY_STORE_EN
        rd_idx = 4'd10;
        #1 chk("store_rd10", rd_key, fips_rk[10]);
        rd_idx = 4'd0;
        #1 chk("store_rd0", rd_key, fips_rk[0]);
        rd_idx = 4'd15;
        #1 chk("store_rd15", rd_key, 128'd0);
        rd_idx = 4'd0;
`endif

        // Run 4: asynchronous reset at round 6.
        push_keys(1'b0, 7);
        pulse_start(fips_rk[0]);
        wait_idx(4'd6);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", {127'b0, rk_valid}, 128'd0);
        chk("arst_key", round_key, 128'd0);
        chk("arst_idx", {124'b0, round_idx}, 128'd0);
        chk("arst_busy", {127'b0, busy}, 128'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        tick();
        chk("arst_stays_idle", {127'b0, busy}, 128'd0);

        // Run 5: all-zero key, covers rcon 1B/36 at rounds 9/10.
        push_keys(1'b1, 11);
        pulse_start(128'h0);
        wait_done();
        tick();
        tick();

        chk("queue_drained", 128'(exp_q.size()), 128'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/aes_key_expand_seq.md
Name: aes_key_expand_seq

Overview:
- Sequential AES-128 key-schedule engine.
- Holds the current round key in a register and forms RotWord of its last word.
- Passes that rotated word through one SubWord instance, then XORs in Rcon.
- Produces round keys 0..10 one per accepted handshake, for the downstream cipher round datapath.

Parameters:
- BYTE, 8, byte width passed to SubWord.
- DWORD, 32, word width passed to SubWord.
- LENGTH, 128, key and round-key width. Only 128 is supported.
- NUM_ROUNDS, 10, last round-key index emitted.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin expansion of key_in. Sampled only in IDLE.
- key_in  input  LENGTH  cipher key. [127:96] is w0 and [31:0] is w3.
- rk_ready  input  1  consumer accepts round_key this cycle.
- rk_valid  output  1  round_key/round_idx are valid.
- round_key  output  LENGTH  current round key, same word order as key_in.
- round_idx  output  4  index of round_key, 0..10.
- busy  output  1  high in every state other than IDLE.
- done  output  1  one-cycle pulse after round 10 is accepted.

Behaviour:
- Reset (asynchronous, rst=1):
  - State goes to IDLE.
  - rk_valid=0, round_key=0, round_idx=0, busy=0, done=0.
  - Rcon register is set to 8'h01.
  - Applies mid-expansion too; no partial output survives reset.
- States:
  - IDLE: waiting for start.
  - EMIT: rk_valid=1.
  - FIN: done=1 for one cycle.
- IDLE with start=1 at edge t:
  - round_key<=key_in, round_idx<=0, rcon<=8'h01.
  - Go to EMIT, so rk_valid=1 from cycle t+1.
- EMIT, when rk_valid and rk_ready are both high at an edge:
  - If round_idx<10: round_key<=next_key, round_idx<=round_idx+1, rcon<=xtime(rcon), stay in EMIT. rk_valid stays high, giving one key per cycle under continuous ready.
  - If round_idx==10: rk_valid<=0, go to FIN.
- EMIT with rk_ready=0: round_key, round_idx and rcon hold stable. rk_valid stays high; it is never dropped while waiting for acceptance.
- FIN: done=1 for exactly one cycle, then IDLE. busy falls in the same cycle done falls.
- next_key, combinational from the round_key register (w0..w3):
  - t = SubWord({w3[23:0], w3[31:24]}) XOR {rcon, 24'h0}
  - n0 = w0^t, n1 = w1^n0, n2 = w2^n1, n3 = w3^n2.
- xtime(r) = {r[6:0],1'b0} ^ (r[7] ? 8'h1B : 8'h00).
  - Rcon sequence: 01,02,04,08,10,20,40,80,1B,36.
- start while busy is ignored; the key is not re-latched.
- start in the same cycle as done is also ignored. It must be reasserted from IDLE.
- key_in is sampled only at the start edge and may change afterwards.
- The only combinational path is round_key through SubWord to the next_key register input. No output depends combinationally on inputs.

Optional Feature:
- Macro: AES_KEY_STORE_EN.
- When defined:
  - Adds an internal 11 x LENGTH key store, written with round_key at each accepted handshake.
  - Adds ports rd_idx (input, 4 bits) and rd_key (output, LENGTH, combinational read).
  - rd_idx>10 returns all zeros.
  - The store is cleared by rst and not cleared by start.
  - Lets the decrypt path read round keys in reverse order.
- When not defined: no store, no rd_* ports, and behaviour is otherwise identical.

Test Plan:
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, start pulse, rk_ready=1 held:
  - rk_valid rises 1 cycle after start.
  - Round 1 = a0fafe1788542cb123a339392a6c7605.
  - Round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - 11 consecutive valid cycles, done pulses the cycle after round 10.
- Backpressure: same key, rk_ready toggled 1,0,0,1,...
  - round_key and round_idx are stable while ready is low.
  - Keys match the no-backpressure run; total handshakes = 11.
- start reasserted at round_idx=4 with a different key_in: ignored, and the sequence completes with the original key.
- rst asserted at round_idx=6, asynchronously between edges:
  - Outputs clear immediately; state is IDLE.
  - A new start with an all-zero key gives round 1 = 62636363626363636263636362636363.
- Rcon wrap check: with the all-zero key, round 9 uses rcon=1B and round 10 uses rcon=36, so round 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- With AES_KEY_STORE_EN: after a full run, rd_idx=10 returns round 10 of the FIPS key, rd_idx=0 returns the key itself, and rd_idx=15 returns 0.
